// File: rtl/lock_pkg.sv
// ---------------------------------------------------------------------------
// lock_pkg
// Shared definitions for the combination-lock controller:
//   - default digit count / digit width
//   - FSM state encoding (plain 2-bit constants)
//   - width helper that never returns zero
// ---------------------------------------------------------------------------
package lock_pkg;

  localparam int DEF_DIGITS  = 4;
  localparam int DEF_DIGIT_W = 4;

  localparam logic [1:0] ST_ENTRY   = 2'd0;
  localparam logic [1:0] ST_CHECK   = 2'd1;
  localparam logic [1:0] ST_OPEN    = 2'd2;
  localparam logic [1:0] ST_LOCKOUT = 2'd3;

  // Bits needed to hold values 0..n-1, at least 1 so vectors stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lock_sequencer_tick_timer.sv
// ---------------------------------------------------------------------------
// tick_timer
// Prescaler plus tick counter shared by the OPEN and LOCKOUT windows.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   i_start      clear both counters (asserted on entry to a timed state)
//   i_run        counters advance only while high; held at 0 otherwise
//   i_last_tick  index of the final tick of the current window
//   o_done       high during the last cycle of the window
// ---------------------------------------------------------------------------
module tick_timer #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_last_tick,
  output logic             o_done
);

  localparam int PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0] r_pre;
  logic [CNT_W-1:0] r_ticks;
  logic             w_tick;

  assign w_tick = (r_pre == PRE_W'(TICK_DIV - 1));
  // Window of N ticks ends on the last prescaler cycle of tick N-1, so the
  // timed state lasts exactly N*TICK_DIV cycles from the clearing edge.
  assign o_done = i_run && w_tick && (r_ticks == i_last_tick);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre   <= '0;
      r_ticks <= '0;
    end else if (i_start || !i_run) begin
      r_pre   <= '0;
      r_ticks <= '0;
    end else if (w_tick) begin
      r_pre   <= '0;
      r_ticks <= r_ticks + CNT_W'(1);
    end else begin
      r_pre   <= r_pre + PRE_W'(1);
    end
  end

endmodule

// File: rtl/lock_sequencer.sv
// ---------------------------------------------------------------------------
// lock_sequencer
// Button-driven combination lock controller.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   next_p     1-cycle pulse: increment the digit being composed
//   enter_p    1-cycle pulse: commit digit / early relock while open
//   code       target code, digit 0 in the LSBs
//   cur_digit  digit value being composed
//   digit_idx  index of the digit being composed
//   unlocked   high while the lock is open
//   alarm      high during the lockout window
//   fail_cnt   consecutive wrong codes
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int DIGITS        = DEF_DIGITS,
  parameter int DIGIT_W       = DEF_DIGIT_W,
  parameter int TICK_DIV      = 50000000,
  parameter int OPEN_TICKS    = 10,
  parameter int LOCKOUT_TICKS = 20,
  parameter int MAX_FAILS     = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             next_p,
  input  logic                             enter_p,
  input  logic [DIGITS*DIGIT_W-1:0]        code,
  output logic [DIGIT_W-1:0]               cur_digit,
  output logic [$clog2(DIGITS)-1:0]        digit_idx,
  output logic                             unlocked,
  output logic                             alarm,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

  localparam int IDX_W  = $clog2(DIGITS);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int MAX_T  = (OPEN_TICKS > LOCKOUT_TICKS) ? OPEN_TICKS : LOCKOUT_TICKS;
  localparam int CNT_W  = idx_width(MAX_T);

  logic [1:0]                r_state, r_state_next;
  logic [DIGIT_W-1:0]        r_cur_digit, r_cur_digit_next;
  logic [IDX_W-1:0]          r_digit_idx, r_digit_idx_next;
  logic [FAIL_W-1:0]         r_fail_cnt, r_fail_cnt_next;
  logic [DIGITS*DIGIT_W-1:0] r_entry, r_entry_next;
  logic                      r_unlocked, r_alarm;

  logic                      w_commit;
  logic                      w_match;
  logic                      w_timer_start;
  logic                      w_timer_run;
  logic                      w_timer_done;
  logic [CNT_W-1:0]          w_last_tick;

  // enter wins over next; a commit only happens while composing
  assign w_commit = (r_state == ST_ENTRY) && enter_p;

  // Each digit slot loads the pre-increment cur_digit when it is committed.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_entry
    assign r_entry_next[gi*DIGIT_W +: DIGIT_W] =
      (w_commit && (r_digit_idx == IDX_W'(gi))) ? r_cur_digit
                                                : r_entry[gi*DIGIT_W +: DIGIT_W];
  end

  // code is only looked at here, so DIP changes mid-entry are harmless
  assign w_match = (r_entry == code);

  assign w_timer_run   = (r_state == ST_OPEN) || (r_state == ST_LOCKOUT);
  assign w_timer_start = (r_state_next != r_state) &&
                         ((r_state_next == ST_OPEN) || (r_state_next == ST_LOCKOUT));
  assign w_last_tick   = (r_state == ST_LOCKOUT) ? CNT_W'(LOCKOUT_TICKS - 1)
                                                 : CNT_W'(OPEN_TICKS - 1);

  tick_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_timer (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_timer_start),
    .i_run       (w_timer_run),
    .i_last_tick (w_last_tick),
    .o_done      (w_timer_done)
  );

  always_comb begin
    r_state_next     = r_state;
    r_cur_digit_next = r_cur_digit;
    r_digit_idx_next = r_digit_idx;
    r_fail_cnt_next  = r_fail_cnt;
    case (r_state)
      ST_ENTRY: begin
        if (enter_p) begin
          r_cur_digit_next = '0;
          if (r_digit_idx == IDX_W'(DIGITS - 1)) begin
            r_digit_idx_next = '0;
            r_state_next     = ST_CHECK;
          end else begin
            r_digit_idx_next = r_digit_idx + IDX_W'(1);
          end
        end else if (next_p) begin
          r_cur_digit_next = r_cur_digit + DIGIT_W'(1);
        end
      end
      ST_CHECK: begin
        if (w_match) begin
          r_fail_cnt_next = '0;
          r_state_next    = ST_OPEN;
        end else if (r_fail_cnt == FAIL_W'(MAX_FAILS - 1)) begin
          r_fail_cnt_next = FAIL_W'(MAX_FAILS);
          r_state_next    = ST_LOCKOUT;
        end else begin
          r_fail_cnt_next = r_fail_cnt + FAIL_W'(1);
          r_state_next    = ST_ENTRY;
        end
      end
      ST_OPEN: begin
        if (w_timer_done || enter_p) begin
          r_state_next = ST_ENTRY;
        end
      end
      ST_LOCKOUT: begin
        if (w_timer_done) begin
          r_fail_cnt_next = '0;
          r_state_next    = ST_ENTRY;
        end
      end
      default: r_state_next = ST_ENTRY;
    endcase
  end

  // Status flags follow the next state so they switch on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ENTRY;
      r_cur_digit <= '0;
      r_digit_idx <= '0;
      r_fail_cnt  <= '0;
      r_entry     <= '0;
      r_unlocked  <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      r_state     <= r_state_next;
      r_cur_digit <= r_cur_digit_next;
      r_digit_idx <= r_digit_idx_next;
      r_fail_cnt  <= r_fail_cnt_next;
      r_entry     <= r_entry_next;
      r_unlocked  <= (r_state_next == ST_OPEN);
      r_alarm     <= (r_state_next == ST_LOCKOUT);
    end
  end

  assign cur_digit = r_cur_digit;
  assign digit_idx = r_digit_idx;
  assign fail_cnt  = r_fail_cnt;
  assign unlocked  = r_unlocked;
  assign alarm     = r_alarm;

endmodule
